// File: rtl/ifetch_responder_if.sv
// ifetch_responder_if: 64-bit instruction memory read port (valid/ready request, pulsed response).
interface ifetch_responder_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        mem_rsp_err;
  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
  );
  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
  );
endinterface

// File: rtl/ifetch_responder.sv
// ifetch_responder: answers fetch-stage addresses with 32-bit instructions from a 64-bit memory port.
// Optional IFETCH_LINE_REUSE_EN keeps the last good line and serves same-line fetches without a request.
module ifetch_responder (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [63:0]               ira,
  input  logic                      pipe_allowin,
  output logic [31:0]               ir,
  output logic                      ivalid,
  ifetch_responder_if.master        mem
);
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] ERR_INST = 32'h0010_0073;
  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;
  state_t      state, state_d;
  logic [60:0] fetch_line;
  logic        fetch_hi;
  logic [31:0] word, word_d;
  logic        accept, misaligned, hit;
  logic [31:0] hit_word;
  assign accept     = ivalid && pipe_allowin;
  assign misaligned = |ira[1:0];
`ifdef IFETCH_LINE_REUSE_EN
  logic        line_valid;
  logic [60:0] line_tag;
  logic [63:0] line_data;
  // Errored responses clear the line so a retry goes back to memory.
  always_ff @(posedge clk)
    if (rst) begin
      line_valid <= 1'b0;
      line_tag   <= '0;
      line_data  <= '0;
    end else if (state == WAIT && mem.mem_rsp_valid) begin
      line_valid <= !mem.mem_rsp_err;
      line_tag   <= fetch_line;
      line_data  <= mem.mem_rsp_data;
    end
  assign hit      = line_valid && line_tag == ira[63:3];
  assign hit_word = ira[2] ? line_data[63:32] : line_data[31:0];
`else
  assign hit      = 1'b0;
  assign hit_word = '0;
`endif
  always_comb begin
    state_d = state;
    word_d  = word;
    case (state)
      BOOT, HOLD:
        if (accept) begin
          state_d = (misaligned || hit) ? HOLD : REQ;
          word_d  = misaligned ? ERR_INST : hit ? hit_word : word;
        end
      REQ: state_d = mem.mem_req_ready ? WAIT : REQ;
      WAIT:
        if (mem.mem_rsp_valid) begin
          state_d = HOLD;
          word_d  = mem.mem_rsp_err ? ERR_INST : fetch_hi ? mem.mem_rsp_data[63:32] : mem.mem_rsp_data[31:0];
        end
      default: state_d = BOOT;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state      <= BOOT;
      word       <= NOP_INST;
      fetch_line <= '0;
      fetch_hi   <= 1'b0;
    end else begin
      state <= state_d;
      word  <= word_d;
      if (accept) begin
        fetch_line <= ira[63:3];
        fetch_hi   <= ira[2];
      end
    end
  assign ivalid            = state == BOOT || state == HOLD;
  assign ir                = state == BOOT ? NOP_INST : word;
  assign mem.mem_req_valid = state == REQ;
  assign mem.mem_req_addr  = {fetch_line, 3'b000};
endmodule

// File: tb/tb_ifetch_responder.sv
// tb_ifetch_responder: directed vector table plus reset/boot sequences against a behavioural memory.
module tb_ifetch_responder;
`ifdef IFETCH_LINE_REUSE_EN
  localparam bit R = 1'b1;
`else
  localparam bit R = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ERR = 32'h0010_0073;
  logic        clk = 1'b0;
  logic        rst, pipe_allowin, ivalid;
  logic [63:0] ira;
  logic [31:0] ir;
  int          checks = 0, errors = 0;
  int          m_stall, m_lat, stall_left, wcnt, req_count;
  logic [63:0] m_data;
  logic        m_err, hs, waiting;
  always #5 clk = ~clk;
  ifetch_responder_if mif ();
  ifetch_responder dut (.clk(clk), .rst(rst), .ira(ira), .pipe_allowin(pipe_allowin), .ir(ir), .ivalid(ivalid), .mem(mif));
  typedef struct {
    logic [63:0] addr;
    int          stall;
    int          lat;
    logic [63:0] data;
    logic        err;
    logic [31:0] exp_ir;
    int          exp_lat;
    int          exp_req;
  } vec_t;
  vec_t vecs[9];
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  // Memory: ready after m_stall request cycles, response m_lat WAIT cycles after the handshake.
  initial begin
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b0;
    mif.mem_rsp_data  = '0;
    mif.mem_rsp_err   = 1'b0;
    hs = 1'b0; waiting = 1'b0; wcnt = 0; req_count = 0;
    forever begin
      @(negedge clk);
      mif.mem_rsp_valid = 1'b0;
      mif.mem_rsp_err   = 1'b0;
      if (hs) begin
        hs = 1'b0; waiting = 1'b1; wcnt = m_lat;
      end
      if (waiting) begin
        if (wcnt <= 1) begin
          mif.mem_rsp_valid = 1'b1;
          mif.mem_rsp_data  = m_data;
          mif.mem_rsp_err   = m_err;
          waiting = 1'b0;
        end else wcnt--;
      end
      mif.mem_req_ready = 1'b0;
      if (mif.mem_req_valid && !waiting) begin
        if (stall_left > 0) stall_left--;
        else begin
          mif.mem_req_ready = 1'b1;
          hs = 1'b1;
          req_count++;
        end
      end
    end
  end
  task automatic do_fetch(input vec_t v, input string tag);
    int cnt, req0;
    m_stall = v.stall; stall_left = v.stall; m_lat = v.lat; m_data = v.data; m_err = v.err;
    req0 = req_count;
    ira = v.addr;
    pipe_allowin = 1'b1;
    @(negedge clk);
    pipe_allowin = 1'b0;
    cnt = 1;
    while (!ivalid && cnt < 60) begin
      if (mif.mem_req_valid) chk({tag, " req_addr"}, mif.mem_req_addr, {v.addr[63:3], 3'b000});
      @(negedge clk);
      cnt++;
    end
    chk({tag, " ivalid"}, 64'(ivalid), 64'd1);
    chk({tag, " ir"}, 64'(ir), 64'(v.exp_ir));
    chk({tag, " latency"}, 64'(cnt), 64'(v.exp_lat));
    chk({tag, " requests"}, 64'(req_count - req0), 64'(v.exp_req));
  endtask
  initial begin
    vec_t v;
    vecs[0] = '{64'h8000_0000, 0, 1, 64'h0050_0093_0000_0297, 1'b0, 32'h0000_0297, 3, 1};
    vecs[1] = '{64'h8000_0004, 0, 1, 64'h0050_0093_0000_0297, 1'b0, 32'h0050_0093, R ? 1 : 3, R ? 0 : 1};
    vecs[2] = '{64'h8000_0010, 4, 1, 64'h1111_1111_2222_2222, 1'b0, 32'h2222_2222, 7, 1};
    vecs[3] = '{64'h8000_0014, 0, 3, 64'h1111_1111_2222_2222, 1'b0, 32'h1111_1111, R ? 1 : 5, R ? 0 : 1};
    vecs[4] = '{64'h8000_0020, 0, 1, 64'h9999_9999_8888_8888, 1'b1, ERR, 3, 1};
    vecs[5] = '{64'h8000_0024, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 32'hAAAA_BBBB, 3, 1};
    vecs[6] = '{64'h8000_0002, 0, 1, 64'h0, 1'b0, ERR, 1, 0};
    vecs[7] = '{64'h8000_0025, 0, 1, 64'h0, 1'b0, ERR, 1, 0};
    vecs[8] = '{64'h8000_0020, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 32'hCCCC_DDDD, R ? 1 : 3, R ? 0 : 1};
    m_stall = 0; stall_left = 0; m_lat = 1; m_data = '0; m_err = 1'b0;
    rst = 1'b1; pipe_allowin = 1'b0; ira = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset req_addr", mif.mem_req_addr, 64'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("boot ivalid", 64'(ivalid), 64'd1);
      chk("boot ir", 64'(ir), 64'(NOP));
      chk("boot req_valid", 64'(mif.mem_req_valid), 64'd0);
    end
    for (int i = 0; i < 9; i++) do_fetch(vecs[i], $sformatf("vec%0d", i));
    // Reset while a request is outstanding; the late response must be ignored.
    m_stall = 0; stall_left = 0; m_lat = 6; m_data = 64'hDEAD_BEEF_DEAD_BEEF; m_err = 1'b0;
    ira = 64'h8000_0040;
    pipe_allowin = 1'b1;
    @(negedge clk);
    pipe_allowin = 1'b0;
    chk("rstwait req_valid", 64'(mif.mem_req_valid), 64'd1);
    @(negedge clk);
    chk("rstwait in_wait", 64'({ivalid, mif.mem_req_valid}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstwait ivalid", 64'(ivalid), 64'd1);
    chk("rstwait ir", 64'(ir), 64'(NOP));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("late rsp ir", 64'({ivalid, ir}), {31'd0, 1'b1, NOP});
      chk("late rsp req_valid", 64'(mif.mem_req_valid), 64'd0);
    end
    v = '{64'h8000_0044, 0, 1, 64'h1234_5678_9ABC_DEF0, 1'b0, 32'h1234_5678, 3, 1};
    do_fetch(v, "post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
